// File: rtl/zone_dtr_sched_pkg.sv
// -----------------------------------------------------------------------------
// zone_dtr_sched_pkg
// Shared definitions for the zone detector scheduler:
//   - default sizing constants (requesters, word width, hit counter width)
//   - 3-bit FSM state encodings and the typed state enum built on them
// -----------------------------------------------------------------------------
package zone_dtr_sched_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;
    localparam int CNTW_DEF  = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CLR   = ST_CLR,
        S_SHIFT = ST_SHIFT,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/zone_dtr_sched_if.sv
// -----------------------------------------------------------------------------
// zone_dtr_sched_if
// Serial link between the scheduler and the external zone detector.
//   det_din   : serial data bit, MSB first
//   det_valid : bit-valid strobe
//   det_clear : active-high synchronous clear of the detector
//   det_zout  : detector match output (Moore, registered in the detector)
// Modports:
//   master : scheduler side (drives din/valid/clear, reads zout)
//   slave  : detector side
// -----------------------------------------------------------------------------
interface zone_dtr_sched_if;

    logic det_din;
    logic det_valid;
    logic det_clear;
    logic det_zout;

    modport master (
        output det_din,
        output det_valid,
        output det_clear,
        input  det_zout
    );

    modport slave (
        input  det_din,
        input  det_valid,
        input  det_clear,
        output det_zout
    );

endinterface

// File: rtl/zone_dtr_sched_arbiter.sv
// -----------------------------------------------------------------------------
// zone_rr_arbiter
// Combinational rotating-priority encoder. Scans req starting at ptr and
// moving upward with wrap; the first set bit wins.
// Ports:
//   req   : NREQ request vector
//   ptr   : index holding highest priority this round
//   gnt   : one-hot winner, all zero when no request
//   idx   : binary index of the winner (0 when no request)
//   found : at least one request is set
// -----------------------------------------------------------------------------
module zone_rr_arbiter
    import zone_dtr_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            found
);

    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    logic [NREQ-1:0] rot_s;
    logic [IW-1:0]   off_s;
    logic [IW:0]     sum_s;

    // Rotate so ptr lands on bit 0, pick lowest set bit, rotate index back.
    always_comb begin
        rot_s = NREQ'({req, req} >> ptr);
        off_s = {IW{1'b0}};
        // Descending scan: the lowest set offset is the last one written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? IW'(k) : off_s;
        end
        found = |req;
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        idx   = (sum_s >= NREQ_W) ? IW'(sum_s - NREQ_W) : sum_s[IW-1:0];
        gnt   = found ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : {NREQ{1'b0}};
    end

endmodule

// File: rtl/zone_dtr_sched.sv
// -----------------------------------------------------------------------------
// zone_dtr_sched
// Round-robin scheduler sharing one serial zone detector among NREQ
// requesters. A granted word is latched, the detector is cleared for one
// cycle, the word is shifted out MSB first for WIDTH cycles, one drain cycle
// catches a match completed by the last bit, then a one-cycle done pulse
// reports the number of detector hits.
// Ports:
//   clk1      : clock, rising edge
//   clear     : asynchronous active-low reset
//   req       : per-requester request, held until done
//   req_data  : word i at [i*WIDTH +: WIDTH]
//   gnt       : one-hot grant (CLR..DONE) or zero
//   busy      : high whenever the FSM is not idle
//   det       : detector link (din/valid/clear out, zout in)
//   done      : one-cycle transfer-complete pulse
//   hit       : hit_count != 0, updated with done
//   hit_count : saturating hit count of the last transfer, held until next done
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module zone_dtr_sched
    import zone_dtr_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                  clk1,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    zone_dtr_sched_if.master      det,
    output logic                  done,
    output logic                  hit,
    output logic [CNTW-1:0]       hit_count
);

    localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [IW-1:0] PTR_LAST = IW'(NREQ - 1);

    // Saturating increment of the hit counter.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
    endfunction

    state_e            state_r, state_s;
    logic [NREQ-1:0]   gnt_r, gnt_s;
    logic [IW-1:0]     gidx_r, gidx_s;
    logic [IW-1:0]     ptr_r, ptr_s;
    logic [WIDTH-1:0]  shift_r, shift_s;
    logic [BW-1:0]     bit_r, bit_s;
    logic [CNTW-1:0]   cnt_r, cnt_s;
    logic              busy_r, busy_s;
    logic              valid_r, valid_s;
    logic              dclr_r, dclr_s;
    logic              done_r, done_s;
    logic              hit_r, hit_s;
    logic [CNTW-1:0]   hitcnt_r, hitcnt_s;

    logic [NREQ-1:0]   arb_gnt_s;
    logic [IW-1:0]     arb_idx_s;
    logic              arb_found_s;

    zone_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_r),
        .gnt   (arb_gnt_s),
        .idx   (arb_idx_s),
        .found (arb_found_s)
    );

    // Next-state and next-output logic; every output flop is loaded from here.
    always_comb begin
        state_s  = state_r;
        gnt_s    = gnt_r;
        gidx_s   = gidx_r;
        ptr_s    = ptr_r;
        shift_s  = shift_r;
        bit_s    = bit_r;
        cnt_s    = cnt_r;
        valid_s  = 1'b0;
        dclr_s   = 1'b0;
        done_s   = 1'b0;
        hit_s    = hit_r;
        hitcnt_s = hitcnt_r;
        case (state_r)
            S_IDLE: begin
                if (arb_found_s) begin
                    state_s = S_CLR;
                    gnt_s   = arb_gnt_s;
                    gidx_s  = arb_idx_s;
                    shift_s = req_data[int'(arb_idx_s) * WIDTH +: WIDTH];
                    cnt_s   = {CNTW{1'b0}};
                    dclr_s  = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLR: begin
                state_s = S_SHIFT;
                bit_s   = {BW{1'b0}};
                valid_s = 1'b1;
            end
            S_SHIFT: begin
                shift_s = {shift_r[WIDTH-2:0], 1'b0};
                // First shift cycle still shows the freshly cleared detector.
                cnt_s = ((bit_r != {BW{1'b0}}) && det.det_zout) ? sat_inc(cnt_r) : cnt_r;
                if (bit_r == BIT_LAST) begin
                    state_s = S_DRAIN;
                    valid_s = 1'b0;
                end else begin
                    bit_s   = bit_r + BW'(1);
                    valid_s = 1'b1;
                end
            end
            S_DRAIN: begin
                // Result of the last bit is only visible now.
                cnt_s    = det.det_zout ? sat_inc(cnt_r) : cnt_r;
                state_s  = S_DONE;
                done_s   = 1'b1;
                hitcnt_s = cnt_s;
                hit_s    = (cnt_s != {CNTW{1'b0}});
            end
            S_DONE: begin
                state_s = S_IDLE;
                gnt_s   = {NREQ{1'b0}};
                // Winner drops to lowest priority for the next round.
                ptr_s   = (gidx_r == PTR_LAST) ? {IW{1'b0}} : gidx_r + IW'(1);
            end
            default: begin
                state_s = S_IDLE;
                gnt_s   = {NREQ{1'b0}};
            end
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk1 or negedge clear) begin
        if (!clear) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk1 or negedge clear) begin
        if (!clear) begin
            gnt_r    <= {NREQ{1'b0}};
            gidx_r   <= {IW{1'b0}};
            ptr_r    <= {IW{1'b0}};
            shift_r  <= {WIDTH{1'b0}};
            bit_r    <= {BW{1'b0}};
            cnt_r    <= {CNTW{1'b0}};
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            dclr_r   <= 1'b1;
            done_r   <= 1'b0;
            hit_r    <= 1'b0;
            hitcnt_r <= {CNTW{1'b0}};
        end else begin
            gnt_r    <= gnt_s;
            gidx_r   <= gidx_s;
            ptr_r    <= ptr_s;
            shift_r  <= shift_s;
            bit_r    <= bit_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            valid_r  <= valid_s;
            dclr_r   <= dclr_s;
            done_r   <= done_s;
            hit_r    <= hit_s;
            hitcnt_r <= hitcnt_s;
        end
    end

    assign gnt           = gnt_r;
    assign busy          = busy_r;
    assign det.det_din   = shift_r[WIDTH-1];
    assign det.det_valid = valid_r;
    assign det.det_clear = dclr_r;
    assign done          = done_r;
    assign hit           = hit_r;
    assign hit_count     = hitcnt_r;

endmodule

// File: tb/tb_zone_dtr_sched.sv
// -----------------------------------------------------------------------------
// tb_zone_dtr_sched
// Directed bench for zone_dtr_sched with a behavioural non-overlapping "101"
// Moore detector on the serial link and a scoreboard of expected grants and
// hit counts popped on every done pulse.
// -----------------------------------------------------------------------------
module tb_zone_dtr_sched;

    logic        clk1;
    logic        clear;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic        hit;
    logic [3:0]  hit_count;

    zone_dtr_sched_if dif ();

    zone_dtr_sched #(
        .NREQ  (4),
        .WIDTH (8),
        .CNTW  (4)
    ) dut (
        .clk1      (clk1),
        .clear     (clear),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .det       (dif),
        .done      (done),
        .hit       (hit),
        .hit_count (hit_count)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Detector model: Moore FSM for "101", restarts after a match.
    logic [1:0] dstate = 2'd0;
    always @(posedge clk1) begin
        if (dif.det_clear) begin
            dstate <= 2'd0;
        end else if (dif.det_valid) begin
            case (dstate)
                2'd0:    dstate <= dif.det_din ? 2'd1 : 2'd0;
                2'd1:    dstate <= dif.det_din ? 2'd1 : 2'd2;
                2'd2:    dstate <= dif.det_din ? 2'd3 : 2'd0;
                default: dstate <= dif.det_din ? 2'd1 : 2'd0;
            endcase
        end
    end
    assign dif.det_zout = (dstate == 2'd3);

    typedef struct {
        int idx;
        int hc;
    } exp_t;

    exp_t sb_q[$];
    logic din_log[$];
    int   checks = 0;
    int   errors = 0;
    int   gnt_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_done(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk1);
            cyc++;
            seen = (done === 1'b1);
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    // Single-requester transfer, started from an idle cycle.
    task automatic run_one(input int idx, input logic [7:0] word, input int exp_hc);
        int cyc;
        @(negedge clk1);
        chk("idle_gnt", {28'd0, gnt}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        req_data[idx*8 +: 8] = word;
        req[idx] = 1'b1;
        sb_q.push_back('{idx, exp_hc});
        @(negedge clk1);
        chk("clr_gnt", {28'd0, gnt}, 32'd1 << idx);
        chk("clr_det_clear", {31'd0, dif.det_clear}, 32'd1);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        req = 4'b0000;
        chk("latency", cyc, 32'd10);
    endtask

    // Monitor: din logging, grant length and scoreboard compare on done.
    always @(negedge clk1) begin
        exp_t e;
        if (!clear) begin
            gnt_run <= 0;
        end else begin
            if (dif.det_valid) din_log.push_back(dif.det_din);
            if (gnt != 4'b0000) begin
                gnt_run <= gnt_run + 1;
            end else if (gnt_run != 0) begin
                chk("gnt_len", gnt_run, 32'd11);
                gnt_run <= 0;
            end else begin
                gnt_run <= 0;
            end
            if (done) begin
                chk("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("done_gnt", {28'd0, gnt}, 32'd1 << e.idx);
                    chk("hit_count", {28'd0, hit_count}, e.hc);
                    chk("hit", {31'd0, hit}, {31'd0, (e.hc != 0)});
                end
            end
        end
    end

    initial begin
        int         cyc;
        logic [7:0] w0;
        w0       = 8'b1010_0000;
        clear    = 1'b0;
        req      = 4'b0000;
        req_data = 32'd0;
        repeat (3) @(negedge clk1);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_det_clear", {31'd0, dif.det_clear}, 32'd1);
        chk("rst_det_valid", {31'd0, dif.det_valid}, 32'd0);
        chk("rst_det_din", {31'd0, dif.det_din}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_hit_count", {28'd0, hit_count}, 32'd0);
        clear = 1'b1;

        // Serial order and valid length for one word.
        din_log.delete();
        run_one(0, w0, 1);
        chk("din_count", din_log.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < din_log.size()) chk("din_bit", {31'd0, din_log[i]}, {31'd0, w0[7-i]});
        end

        run_one(1, 8'b1010_1010, 2);
        repeat (3) @(negedge clk1);
        chk("hold_hit_count", {28'd0, hit_count}, 32'd2);
        chk("hold_hit", {31'd0, hit}, 32'd1);
        run_one(1, 8'b1011_0101, 2);
        run_one(1, 8'hFF, 0);
        run_one(3, 8'b0000_0101, 1);

        // All four requesting continuously: rotate 0,1,2,3,0.
        @(negedge clk1);
        req_data = {8'b0000_0101, 8'b1011_0101, 8'b1010_1010, 8'b1010_0000};
        req      = 4'b1111;
        sb_q.push_back('{0, 1});
        sb_q.push_back('{1, 2});
        sb_q.push_back('{2, 2});
        sb_q.push_back('{3, 1});
        sb_q.push_back('{0, 1});
        @(negedge clk1);
        chk("rr_first_gnt", {28'd0, gnt}, 32'd1);
        wait_done(cyc);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk1);
            chk("rr_gap_gnt", {28'd0, gnt}, 32'd0);
            chk("rr_gap_busy", {31'd0, busy}, 32'd0);
            @(negedge clk1);
            chk("rr_gnt", {28'd0, gnt}, 32'd1 << (k % 4));
            wait_done(cyc);
            chk("rr_latency", cyc, 32'd10);
        end
        req = 4'b0000;

        // Request dropped and data changed mid-shift: latched word still used.
        @(negedge clk1);
        req_data[23:16] = 8'b1010_1010;
        req = 4'b0100;
        sb_q.push_back('{2, 2});
        repeat (5) @(negedge clk1);
        req = 4'b0000;
        req_data[23:16] = 8'hFF;
        wait_done(cyc);
        chk("drop_latency", cyc, 32'd6);

        // Reset mid-shift aborts; pointer returns to 0.
        @(negedge clk1);
        req_data[15:8] = 8'b1010_0000;
        req = 4'b0010;
        repeat (5) @(negedge clk1);
        clear = 1'b0;
        req = 4'b0000;
        @(negedge clk1);
        chk("abort_gnt", {28'd0, gnt}, 32'd0);
        chk("abort_det_clear", {31'd0, dif.det_clear}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_det_valid", {31'd0, dif.det_valid}, 32'd0);
        chk("abort_hit_count", {28'd0, hit_count}, 32'd0);
        repeat (2) begin
            @(negedge clk1);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        clear = 1'b1;
        @(negedge clk1);
        req_data[31:24] = 8'hFF;
        req = 4'b1010;
        sb_q.push_back('{1, 1});
        @(negedge clk1);
        chk("post_rst_gnt", {28'd0, gnt}, 32'd2);
        wait_done(cyc);
        req = 4'b0000;
        chk("post_rst_latency", cyc, 32'd10);

        repeat (5) @(negedge clk1);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zone_dtr_sched.md
Name: zone_dtr_sched

Overview:
- Round-robin scheduler that shares one serial zone detector among NREQ requesters.
- Each requester offers a parallel WIDTH-bit word. The scheduler grants one requester and pre-clears the detector. It then shifts the word in MSB-first with a bit-valid strobe.
- It counts detector hits (Zout pulses) and reports the count per transfer.
- Sits between requester logic and the external detector instance: drives its din/valid/clear, reads its zout.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 8, bits per word shifted into the detector.
- CNTW, 4, width of hit_count. Count saturates at 2^CNTW-1.

Ports:
- clk1, input, 1, single clock, rising edge.
- clear, input, 1, asynchronous active-low reset (reset while 0).
- req, input, NREQ, per-requester request. Held high until done for that requester.
- req_data, input, NREQ*WIDTH, word i at bits [i*WIDTH +: WIDTH].
- gnt, output, NREQ, one-hot grant, or all zero.
- busy, output, 1, high whenever state != IDLE.
- det_din, output, 1, serial data bit to detector.
- det_valid, output, 1, bit-valid strobe to detector.
- det_clear, output, 1, active-high clear to detector.
- det_zout, input, 1, detector match output (Moore, registered state).
- done, output, 1, one-cycle pulse: transfer complete.
- hit, output, 1, with done: hit_count != 0.
- hit_count, output, CNTW, hits in last transfer. Held until next done.

Behaviour:
- Reset (clear=0, async):
  - state=IDLE, gnt=0, det_valid=0, det_din=0, det_clear=1, done=0, hit=0, hit_count=0.
  - Round-robin pointer=0.
  - Reset mid-transfer aborts immediately. No done is produced.
- All outputs are registered.
- FSM states: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - det_clear=0, det_valid=0.
  - If any req is set: pick the first set bit scanning from the pointer upward with wrap.
  - Set gnt (one-hot), latch that word into the shift register, zero the count, go to CLR.
  - Arbitration takes 1 cycle. gnt asserts on the edge leaving IDLE.
- CLR (1 cycle): det_clear=1, det_valid=0. Go to SHIFT with bit counter=0.
- SHIFT (exactly WIDTH cycles):
  - det_valid=1, det_din=shift_reg MSB, shift left each cycle.
  - In SHIFT cycles 1..WIDTH-1, sample det_zout=1 and increment the count (saturating).
  - Cycle 0 sample is ignored (detector just cleared).
  - After cycle WIDTH-1, go to DRAIN.
- DRAIN (1 cycle):
  - det_valid=0. Sample det_zout once more; this captures a match completed by the last bit.
  - Go to DONE.
- DONE (1 cycle):
  - done=1; hit_count=count; hit=(count!=0).
  - gnt cleared on exit. Pointer = granted index+1 mod NREQ. Go to IDLE.
- Per-transfer latency:
  - IDLE with req -> done high = 1 + 1 + WIDTH + 1 + 1 cycles (12 for WIDTH=8).
  - Minimum spacing between transfers is the same. IDLE is always visited for at least 1 cycle.
- Requests and data during a transfer:
  - req/req_data changes during a transfer are ignored; the word is latched in IDLE.
  - A req dropped before done still completes.
- Simultaneous requests: only the round-robin winner is served. Others wait. No starvation: every set req is served within NREQ transfers.
- Requester still high at DONE: eligible again, but at lowest priority.
- Each detector hit is exactly one cycle high while valid continues, so no double counting.

Decomposition:
- Shared package: FSM state encodings (3-bit localparams ST_IDLE..ST_DONE); the default WIDTH/NREQ/CNTW constants.
- One sub-module: zone_rr_arbiter (NREQ-wide, rotating-pointer priority encoder, req + pointer -> one-hot gnt + index).
- FSM, shift register and counter stay in the top module.

Test Plan:
- Reset: drive clear=0 mid-SHIFT -> gnt=0, det_clear=1, busy=0, no done. After release, the next req is served from pointer 0.
- Single req[0], word 8'b10100000 -> det_din sequence 1,0,1,0,0,0,0,0 with det_valid high 8 cycles; done at cycle 12; hit_count=1, hit=1.
- req[1], word 8'b10101010 -> hit_count=2. Word 8'b10110101 -> hit_count=2. Word 8'hFF -> hit_count=0, hit=0.
- Last-bit match: word 8'b00000101 -> hit caught in DRAIN; hit_count=1.
- req=4'b1111 held continuously -> gnt order 0001, 0010, 0100, 1000, 0001. Each gnt lasts CLR..DONE (11 cycles), and gnt=0 for 1 IDLE cycle between grants.
- req[2] dropped and req_data[2] changed mid-SHIFT -> transfer completes with the latched word, correct hit_count, done pulse.
